// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencer state type for the ALU slice.
// Used by both the sequencer FSM and the primitive ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Unsigned 8-bit ALU; result/flag registers update one cycle after load.
// No flow control: the registers hold their value whenever load is low.
module PrimitiveALU
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       flag
);

    logic [7:0] y;
    logic       f;

    always_comb begin
        y = 8'd0;
        f = 1'b0;
        case (op)
            OP_ADD:  {f, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y = a - b;
                f = (b > a);
            end
            OP_MUL:  {f, y} = {1'b0, a} * {1'b0, b};
            // Zero divisor is never loaded; the guard only keeps y defined.
            OP_DIV:  y = (b == 8'd0) ? 8'd0 : a / b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            default: y = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 8'd0;
            flag   <= 1'b0;
        end else if (load) begin
            result <= y;
            flag   <= f;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer around PrimitiveALU: IDLE accepts, EXEC computes, DONE holds result.
// Result valid two cycles after accept; DONE holds until res_ready, no bypass into IDLE.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter logic [7:0] ERR_VALUE = 8'hFF,
    parameter logic [7:0] ACC_INIT  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_chain,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_flag,
    output logic       res_err,
    output logic [7:0] acc,
    output logic [7:0] op_count
);

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic       acc_vld;
    logic       alu_load;
    logic       div_zero;
    logic [7:0] alu_result;
    logic       alu_flag;

    assign div_zero = (op_q == OP_DIV) && (b_q == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_load  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = EXEC;
            end
            EXEC: begin
                alu_load  = !div_zero;
                state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The ALU result register doubles as the accumulator: an error result
    // skips the load, so acc naturally keeps its previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            res_err  <= 1'b0;
            acc_vld  <= 1'b0;
            op_count <= 8'd0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                op_q <= cmd_op;
                a_q  <= cmd_chain ? acc : cmd_a;
                b_q  <= cmd_b;
            end
            if (state == EXEC) begin
                res_err  <= div_zero;
                op_count <= op_count + 8'd1;
                if (!div_zero) acc_vld <= 1'b1;
            end
        end
    end

    assign acc      = acc_vld ? alu_result : ACC_INIT;
    assign res_data = res_err ? ERR_VALUE : alu_result;
    assign res_flag = res_err ? 1'b0 : alu_flag;

    PrimitiveALU u_alu (
        .clk    (clk),
        .rst    (rst),
        .load   (alu_load),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flag   (alu_flag)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_flag;
    logic       res_err;
    logic [7:0] acc;
    logic [7:0] op_count;

    int n_chk = 0;
    int n_err = 0;
    int lat;
    int seen;

    always #5 clk = ~clk;

    alu_sequencer #(.ERR_VALUE(8'hFF), .ACC_INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .res_err   (res_err),
        .acc       (acc),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command, wait (bounded) for res_valid; leaves DUT in DONE.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic chain, output int latency);
        @(negedge clk);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        latency = 0;
        while (!res_valid && latency < 8) begin
            @(negedge clk);
            latency++;
        end
        if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic release_res;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic chain,
                       input logic [7:0] exp_d, input logic exp_f, input logic [7:0] exp_cnt);
        int l;
        issue(op, a, b, chain, l);
        chk({tag, "_data"}, 32'(res_data), 32'(exp_d));
        chk({tag, "_flag"}, 32'(res_flag), 32'(exp_f));
        chk({tag, "_err"},  32'(res_err),  32'd0);
        chk({tag, "_cnt"},  32'(op_count), 32'(exp_cnt));
        release_res();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_chain = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_flag",  32'(res_flag),  32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_acc",       32'(acc),       32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);

        // ADD 200+100 = 300 -> 44 carry 1
        issue(3'd0, 8'd200, 8'd100, 1'b0, lat);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_data", 32'(res_data), 32'd44);
        chk("add_flag", 32'(res_flag), 32'd1);
        chk("add_acc",  32'(acc), 32'd44);
        chk("add_cnt",  32'(op_count), 32'd1);
        chk("add_cmd_ready_done", 32'(cmd_ready), 32'd0);
        release_res();
        chk("add_back_idle", 32'(cmd_ready), 32'd1);

        // chain: 44-50 -> 250 borrow; 250*2 = 500 -> 244 bit8 set
        run("sub_chain", 3'd1, 8'd0, 8'd50, 1'b1, 8'd250, 1'b1, 8'd2);
        chk("sub_chain_acc", 32'(acc), 32'd250);
        run("mul_chain", 3'd2, 8'd0, 8'd2,  1'b1, 8'd244, 1'b1, 8'd3);
        chk("mul_chain_acc", 32'(acc), 32'd244);

        // divide by zero
        issue(3'd3, 8'd9, 8'd0, 1'b0, lat);
        chk("div0_data", 32'(res_data), 32'hFF);
        chk("div0_err",  32'(res_err),  32'd1);
        chk("div0_flag", 32'(res_flag), 32'd0);
        chk("div0_acc",  32'(acc),      32'd244);
        chk("div0_cnt",  32'(op_count), 32'd4);
        release_res();

        run("div",     3'd3, 8'd200, 8'd7,   1'b0, 8'd28,  1'b0, 8'd5);
        run("and",     3'd4, 8'hF0,  8'h3C,  1'b0, 8'h30,  1'b0, 8'd6);
        run("or",      3'd5, 8'hF0,  8'h3C,  1'b0, 8'hFC,  1'b0, 8'd7);
        run("xor",     3'd6, 8'hF0,  8'h3C,  1'b0, 8'hCC,  1'b0, 8'd8);
        run("not",     3'd7, 8'h0F,  8'hAA,  1'b0, 8'hF0,  1'b0, 8'd9);
        run("sub_nob", 3'd1, 8'd100, 8'd30,  1'b0, 8'd70,  1'b0, 8'd10);
        run("sub_eq",  3'd1, 8'd30,  8'd30,  1'b0, 8'd0,   1'b0, 8'd11);
        run("add_noc", 3'd0, 8'd1,   8'd2,   1'b0, 8'd3,   1'b0, 8'd12);
        chk("add_noc_acc", 32'(acc), 32'd3);

        // backpressure: hold result for 5 cycles while a new command is offered
        issue(3'd0, 8'd5, 8'd6, 1'b0, lat);
        cmd_op    = 3'd2;
        cmd_a     = 8'd77;
        cmd_b     = 8'd3;
        cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_data",  32'(res_data),  32'd11);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        release_res();
        chk("bp_idle_res_valid", 32'(res_valid), 32'd0);
        chk("bp_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bp_cnt", 32'(op_count), 32'd13);
        chk("bp_acc", 32'(acc), 32'd11);

        // reset asserted while in EXEC
        @(negedge clk);
        cmd_op    = 3'd0;
        cmd_a     = 8'd10;
        cmd_b     = 8'd20;
        cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rexec_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rexec_res_valid", 32'(res_valid), 32'd0);
        chk("rexec_res_data",  32'(res_data),  32'd0);
        chk("rexec_acc",       32'(acc),       32'd0);
        chk("rexec_cnt",       32'(op_count),  32'd0);
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("rexec_no_result", 32'(seen), 32'd0);

        // first chained command after reset uses ACC_INIT as A
        run("chain_init", 3'd0, 8'd99, 8'd7, 1'b1, 8'd7, 1'b0, 8'd1);
        chk("chain_init_acc", 32'(acc), 32'd7);

        // 255 more completions gives 256 since reset: op_count wraps to 0
        for (int i = 0; i < 255; i++) begin
            issue(3'd0, 8'(i), 8'd1, 1'b0, lat);
            release_res();
        end
        chk("wrap_cnt", 32'(op_count), 32'd0);
        chk("wrap_acc", 32'(acc), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
